fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO, successor to the fixed 64x8 buffer.
//  Adds full/empty/almost flags, fill level, simultaneous read+write, flush,
//  sticky overflow/underflow and a selectable first-word-fall-through read mode.
//  Sits between streaming producers (valid/backpressure) and request-driven consumers.
// PARAMETERS
//  WIDTH     64        data word width, >=1
//  DEPTH     8         entries; power of two, >=2
//  FWFT      0         0: registered read on request; 1: head word presented without request
//  AF_LEVEL  DEPTH-1   almost_full_o asserted when level >= AF_LEVEL
//  AE_LEVEL  1         almost_empty_o asserted when level <= AE_LEVEL
// PORTS
//  clock_i         in   1              clock, rising edge
//  rst_n_i         in   1              reset, asynchronous, active-low
//  flush_i         in   1              synchronous clear of contents and error flags
//  data_in_i       in   WIDTH          write data
//  data_in_v_i     in   1              write valid
//  data_in_bkp_o   out  1              backpressure; equals full_o
//  data_out_o      out  WIDTH          read data
//  data_out_v_o    out  1              read data valid
//  data_out_req_i  in   1              read request / pop
//  level_o         out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  full_o          out  1              level == DEPTH
//  empty_o         out  1              level == 0
//  almost_full_o   out  1              level >= AF_LEVEL
//  almost_empty_o  out  1              level <= AE_LEVEL
//  overflow_o      out  1              sticky: write attempted while full
//  underflow_o     out  1              sticky: request while empty
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers 0, level_o 0, data_out_o 0, data_out_v_o 0,
//    empty_o 1, almost_empty_o 1, full_o 0, almost_full_o 0, overflow_o/underflow_o 0. Storage not reset.
//  - Pointers ADDR_W+1 bits with a wrap bit; level = wr_ptr - rd_ptr modulo 2^(ADDR_W+1).
//    Full = addresses equal, wrap bits differ. Flags derive from registered pointers only.
//  - Write accepted iff data_in_v_i && !full_o at the clock edge. Write while full: data dropped,
//    overflow_o set. A same-cycle pop does not unblock a write when full.
//  - FWFT=0: pop iff data_out_req_i && !empty_o. data_out_o <= head and data_out_v_o <= 1 on the next edge
//    (1-cycle latency). data_out_v_o is a 1-cycle pulse per pop. data_out_o holds its value otherwise.
//  - FWFT=1: data_out_o = head (combinational from storage), data_out_v_o = !empty_o.
//    data_out_req_i && data_out_v_o pops. A written word is visible the cycle after its write edge.
//  - Request while empty_o: no pop, underflow_o set. FWFT=0 drives data_out_v_o 0 on the next cycle.
//    A request is not served by a write in the same cycle.
//  - Simultaneous accepted write and pop: both occur, level unchanged. Ordering is strict FIFO across wrap.
//  - flush_i has priority over same-cycle write/pop. Next cycle: pointers 0, level 0, data_out_v_o 0,
//    overflow_o/underflow_o 0. data_out_o is unchanged.
//  - Sticky errors clear only on reset or flush.
//  - Reset mid-operation: all outputs go to reset values immediately, without a clock edge.
// STRUCTURE
//  - fifo_pkg: fifo_addr_w(DEPTH) function, level typedef helper, default threshold constants.
//  - Sub-module fifo_mem: DEPTH x WIDTH storage, 1 write port, 1 async read port, no reset.
//  - Top holds pointers, flags, error bits and the FWFT output stage.
//  - Elaboration checks: DEPTH power of two; AF_LEVEL and AE_LEVEL within 0..DEPTH.
// TESTING  (WIDTH=64, DEPTH=8 unless stated)
//  1. Fill: write 0x1..0x8 with no requests, then a 9th write of 0x9.
//     -> full_o/bkp=1 after the 8th write, level_o=8, almost_full_o from level 7,
//        0x9 dropped, overflow_o=1.
//  2. Drain (FWFT=0): 8 consecutive requests -> data_out_o 0x1..0x8, each one cycle after its request,
//     data_out_v_o high 8 cycles. A 9th request gives data_out_v_o=0 and underflow_o=1.
//  3. Wrap: write 5, read 5, write 8, read 8 -> output order exact, level_o ends at 0, empty_o=1.
//  4. Concurrent: at level 4, write+request every cycle for 10 cycles -> level_o stays 4,
//     output sequence continues in order.
//  5. Flush: at level 6 with overflow_o=1, pulse flush_i alongside a write -> next cycle level_o=0,
//     empty_o=1, overflow_o=0, the written word is never output.
//  6. FWFT=1: write 0xA5 into empty FIFO -> data_out_v_o=1, data_out_o=0xA5 the next cycle.
//     A request pops it. Then assert rst_n_i low mid-stream -> all outputs reset with no clock edge.

Source files
------------

// File: rtl/fifo_sync_param_pkg.sv
// Shared constants and sizing helpers for the parametrised synchronous FIFO.
package fifo_sync_param_pkg;

    localparam int FIFO_DEF_WIDTH    = 64;
    localparam int FIFO_DEF_DEPTH    = 8;
    localparam int FIFO_DEF_AE_LEVEL = 1;

    // Read-side behaviour of the output stage.
    typedef enum logic {
        RD_REGISTERED = 1'b0,
        RD_FWFT       = 1'b1
    } rd_mode_e;

    // Address bits needed to index DEPTH entries (never less than one).
    function automatic int fifo_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Level counter width: one extra bit so the value DEPTH is representable.
    function automatic int fifo_lvl_w(input int depth);
        return fifo_addr_w(depth) + 1;
    endfunction

    function automatic bit fifo_is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle of the FIFO; slave is the FIFO side.
interface fifo_sync_param_if
    import fifo_sync_param_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH
);
    localparam int LVL_W = fifo_lvl_w(DEPTH);

    logic             flush_i;
    logic [WIDTH-1:0] data_in_i;
    logic             data_in_v_i;
    logic             data_in_bkp_o;
    logic [WIDTH-1:0] data_out_o;
    logic             data_out_v_o;
    logic             data_out_req_i;
    logic [LVL_W-1:0] level_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic             overflow_o;
    logic             underflow_o;

    modport slave (
        input  flush_i, data_in_i, data_in_v_i, data_out_req_i,
        output data_in_bkp_o, data_out_o, data_out_v_o, level_o, full_o, empty_o,
               almost_full_o, almost_empty_o, overflow_o, underflow_o
    );

    modport master (
        output flush_i, data_in_i, data_in_v_i, data_out_req_i,
        input  data_in_bkp_o, data_out_o, data_out_v_o, level_o, full_o, empty_o,
               almost_full_o, almost_empty_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/fifo_sync_param_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_sync_param_mem
    import fifo_sync_param_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH,
    localparam int ADDR_W = fifo_addr_w(DEPTH)
) (
    input  logic              clock_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry on an accepted write.
    always_ff @(posedge clock_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with level/almost flags, sticky errors, flush
// and selectable registered or first-word-fall-through read stage.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int WIDTH    = FIFO_DEF_WIDTH,
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = FIFO_DEF_AE_LEVEL
) (
    input  logic               clock_i,
    input  logic               rst_n_i,
    fifo_sync_param_if.slave   bus
);

    localparam int       ADDR_W = fifo_addr_w(DEPTH);
    localparam int       LVL_W  = ADDR_W + 1;
    localparam rd_mode_e MODE   = (FWFT != 0) ? RD_FWFT : RD_REGISTERED;

    if (!fifo_is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_lvl
        $error("fifo_sync_param: AF_LEVEL/AE_LEVEL must lie in 0..DEPTH");
    end

    localparam logic [LVL_W-1:0] AF_L = LVL_W'(AF_LEVEL);
    localparam logic [LVL_W-1:0] AE_L = LVL_W'(AE_LEVEL);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic [LVL_W-1:0]  level;
    logic              full, empty, wr_acc, pop;
    logic [WIDTH-1:0]  head;

    // Occupancy comes purely from registered pointers; the wrap bit separates full from empty.
    assign level  = wr_ptr_q - rd_ptr_q;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                    (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    // A pop in the same cycle never frees space for a write, nor does a write feed a request.
    assign wr_acc = bus.data_in_v_i && !full;
    assign pop    = bus.data_out_req_i && !empty;

    // Next-state for pointers and sticky errors; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
            if (bus.data_in_v_i && full)      ovf_d = 1'b1;
            if (bus.data_out_req_i && empty)  udf_d = 1'b1;
        end
    end

    // Pointer and error registers, asynchronously cleared.
    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_sync_param_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock_i (clock_i),
        .we_i    (wr_acc && !bus.flush_i),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (bus.data_in_i),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (head)
    );

    if (MODE == RD_REGISTERED) begin : g_reg_rd
        logic [WIDTH-1:0] dout_q;
        logic             dv_q;

        // Registered read: capture the head on a pop, one-cycle valid pulse; data holds otherwise.
        always_ff @(posedge clock_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else if (bus.flush_i) begin
                dv_q   <= 1'b0;
            end else begin
                dv_q   <= pop;
                if (pop) dout_q <= head;
            end
        end

        assign bus.data_out_o   = dout_q;
        assign bus.data_out_v_o = dv_q;
    end else begin : g_fwft_rd
        // Head shown directly; zeroed while empty so reset leaves the bus at 0.
        assign bus.data_out_o   = empty ? '0 : head;
        assign bus.data_out_v_o = !empty;
    end

    assign bus.level_o        = level;
    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.data_in_bkp_o  = full;
    assign bus.almost_full_o  = (level >= AF_L);
    assign bus.almost_empty_o = (level <= AE_L);
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = udf_q;

endmodule
